// File: rtl/fma_pkg.sv
// Shared types and widths for the FMA multiply request/result interface.
package fma_pkg;

    localparam int MUL_W   = 27;
    localparam int PROD_W  = 54;
    localparam int LAT_MAX = 4;

    typedef struct packed {
        logic             vld;
        logic             id;
        logic [MUL_W-1:0] a;
        logic [MUL_W-1:0] b;
    } mulit;

    typedef struct packed {
        logic              vld;
        logic              id;
        logic [PROD_W-1:0] prod;
    } mulot;

endpackage

// File: rtl/mul_pipe.sv
// LAT-stage 27x27 unsigned multiplier with parallel valid/id shift registers.
// Flush clears every valid bit on the next edge; data registers are left alone.
module mul_pipe
    import fma_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  mulit op_i,
    output mulot res_o
);

    localparam int PW = (LAT > 1) ? LAT - 1 : 1;

    logic [LAT-1:0]    vld_q, vld_d;
    logic [LAT-1:0]    id_q, id_d;
    logic [MUL_W-1:0]  a_q, a_d;
    logic [MUL_W-1:0]  b_q, b_d;
    logic [PROD_W-1:0] prod_q [PW];
    logic [PROD_W-1:0] prod_d [PW];
    logic [PROD_W-1:0] prod_s1;

    // Operands sit in stage 1; the product is formed there and retimed down the remaining stages.
    assign prod_s1 = PROD_W'(a_q) * PROD_W'(b_q);

    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = op_i.vld & ~flush;
        id_d[0]  = op_i.id;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
            id_d[i]  = id_q[i-1];
        end
        a_d       = op_i.vld ? op_i.a : a_q;
        b_d       = op_i.vld ? op_i.b : b_q;
        prod_d[0] = prod_s1;
        for (int i = 1; i < PW; i++) begin
            prod_d[i] = prod_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            for (int i = 0; i < PW; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            a_q   <= a_d;
            b_q   <= b_d;
            for (int i = 0; i < PW; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign res_o = '{vld:  vld_q[LAT-1],
                     id:   id_q[LAT-1],
                     prod: (LAT == 1) ? prod_s1 : prod_q[PW-1]};

endmodule

// File: rtl/mul_srv.sv
// Shared-multiplier responder: round-robin arbiter over two requester ports,
// one pipelined multiplier, and per-port result registers that hold between results.
module mul_srv
    import fma_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0,
    input  logic [MUL_W-1:0]  a0,
    input  logic [MUL_W-1:0]  b0,
    output logic              gnt0,
    output logic              vld0,
    output logic [PROD_W-1:0] out0,
    input  logic              req1,
    input  logic [MUL_W-1:0]  a1,
    input  logic [MUL_W-1:0]  b1,
    output logic              gnt1,
    output logic              vld1,
    output logic [PROD_W-1:0] out1
);

    logic              last_q, last_d;
    logic [PROD_W-1:0] out0_q, out0_d;
    logic [PROD_W-1:0] out1_q, out1_d;
    mulit              op;
    mulot              res;

    // On conflict the port that was not granted most recently wins; no grants while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset && !flush) begin
            if (req0 && (!req1 || last_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
        op = '{vld: gnt0 | gnt1,
               id:  gnt1,
               a:   gnt1 ? a1 : a0,
               b:   gnt1 ? b1 : b0};
    end

    mul_pipe #(
        .LAT(LAT)
    ) u_pipe (
        .clk  (clk),
        .rst_n(reset),
        .flush(flush),
        .op_i (op),
        .res_o(res)
    );

    // Results are presented in the cycle they leave the final stage, then held.
    always_comb begin
        vld0   = res.vld & ~res.id;
        vld1   = res.vld & res.id;
        out0   = vld0 ? res.prod : out0_q;
        out1   = vld1 ? res.prod : out1_q;
        out0_d = out0;
        out1_d = out1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            last_q <= last_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

endmodule

// File: tb/tb_mul_srv.sv
// Scoreboard bench for mul_srv: driver predicts grants and pushes expected products,
// a negedge monitor pops and compares whenever a port presents a result.
module tb_mul_srv;
    import fma_pkg::*;

    localparam int LAT = 3;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              req0  = 1'b0;
    logic              req1  = 1'b0;
    logic [MUL_W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic              gnt0, gnt1, vld0, vld1;
    logic [PROD_W-1:0] out0, out1;

    mul_srv #(
        .LAT(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .req0 (req0),
        .a0   (a0),
        .b0   (b0),
        .gnt0 (gnt0),
        .vld0 (vld0),
        .out0 (out0),
        .req1 (req1),
        .a1   (a1),
        .b1   (b1),
        .gnt1 (gnt1),
        .vld1 (vld1),
        .out1 (out1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [PROD_W-1:0] prod;
    } exp_t;

    exp_t              sbq [2][$];
    logic [PROD_W-1:0] outm [2];
    logic              last_m = 1'b1;
    int                cyc    = 0;
    int                n_cmp  = 0;
    int                n_bad  = 0;

    logic              pend [2];
    logic [MUL_W-1:0]  pa [2];
    logic [MUL_W-1:0]  pb [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, predict the grant from the round-robin rule and enqueue the product.
    task automatic applyStimulus(input logic rst_v, input logic fl,
                                 input logic r0, input logic [MUL_W-1:0] x0, input logic [MUL_W-1:0] y0,
                                 input logic r1, input logic [MUL_W-1:0] x1, input logic [MUL_W-1:0] y1,
                                 output logic g0, output logic g1);
        @(posedge clk);
        #1;
        reset = rst_v;
        flush = fl;
        req0  = r0;
        a0    = x0;
        b0    = y0;
        req1  = r1;
        a1    = x1;
        b1    = y1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst_v) begin
            for (int p = 0; p < 2; p++) begin
                sbq[p].delete();
                outm[p] = '0;
            end
            last_m = 1'b1;
        end else if (fl) begin
            for (int p = 0; p < 2; p++) begin
                while (sbq[p].size() > 0 && sbq[p][sbq[p].size()-1].due > cyc) begin
                    void'(sbq[p].pop_back());
                end
            end
        end else if (r0 && r1) begin
            g0 = last_m;
            g1 = !last_m;
        end else begin
            g0 = r0;
            g1 = r1;
        end
        checkOutput("gnt0", 64'(gnt0), 64'(g0));
        checkOutput("gnt1", 64'(gnt1), 64'(g1));
        if (g0) begin
            sbq[0].push_back('{cyc + LAT, PROD_W'(x0) * PROD_W'(y0)});
            last_m = 1'b0;
        end
        if (g1) begin
            sbq[1].push_back('{cyc + LAT, PROD_W'(x1) * PROD_W'(y1)});
            last_m = 1'b1;
        end
    endtask

    task automatic checkPort(input int p, input logic v, input logic [PROD_W-1:0] o);
        exp_t e;
        if (v !== 1'b0) begin
            if (sbq[p].size() == 0) begin
                checkOutput($sformatf("vld%0d_spurious", p), 64'(v), 64'd0);
            end else begin
                e = sbq[p].pop_front();
                checkOutput($sformatf("out%0d", p), 64'(o), 64'(e.prod));
                checkOutput($sformatf("vld%0d_cycle", p), 64'(cyc), 64'(e.due));
                outm[p] = e.prod;
            end
        end else begin
            if (sbq[p].size() > 0 && sbq[p][0].due <= cyc) begin
                e = sbq[p].pop_front();
                checkOutput($sformatf("vld%0d_missing", p), 64'(v), 64'd1);
                outm[p] = e.prod;
            end
            checkOutput($sformatf("out%0d_hold", p), 64'(o), 64'(outm[p]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkPort(0, vld0, out0);
            checkPort(1, vld1, out1);
        end
    end

    function automatic logic [MUL_W-1:0] randOp();
        case ($urandom_range(7))
            0:       return '0;
            1:       return 27'h7FFFFFF;
            default: return MUL_W'($urandom);
        endcase
    endfunction

    task automatic setReq(input int p, input logic [MUL_W-1:0] x, input logic [MUL_W-1:0] y);
        pend[p] = 1'b1;
        pa[p]   = x;
        pb[p]   = y;
    endtask

    // Losing requesters keep request and operands; new requests start with probability newp%.
    task automatic stepPorts(input logic fl, input int newp, input bit drop);
        logic g0, g1;
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && int'($urandom_range(99)) < newp) begin
                setReq(p, randOp(), randOp());
            end
        end
        applyStimulus(1'b1, fl, pend[0], pa[0], pb[0], pend[1], pa[1], pb[1], g0, g1);
        if (g0) pend[0] = 1'b0;
        if (g1) pend[1] = 1'b0;
        if (drop) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && $urandom_range(15) == 0) pend[p] = 1'b0;
            end
        end
    endtask

    task automatic resetCycles(input int n);
        logic g0, g1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
    endtask

    task automatic idle(input int n);
        repeat (n) stepPorts(1'b0, 0, 1'b0);
    endtask

    initial begin
        outm[0] = '0;
        outm[1] = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pa[0] = '0; pb[0] = '0; pa[1] = '0; pb[1] = '0;
        #1 reset = 1'b0;

        $display("[TB] reset");
        resetCycles(3);

        $display("[TB] single request 3*5");
        setReq(0, 27'd3, 27'd5);
        stepPorts(1'b0, 0, 1'b0);
        idle(5);

        $display("[TB] conflict from reset 2*7 vs 4*9");
        resetCycles(1);
        setReq(0, 27'd2, 27'd7);
        setReq(1, 27'd4, 27'd9);
        stepPorts(1'b0, 0, 1'b0);
        stepPorts(1'b0, 0, 1'b0);
        idle(5);

        $display("[TB] maximum operands");
        setReq(0, 27'h7FFFFFF, 27'h7FFFFFF);
        stepPorts(1'b0, 0, 1'b0);
        idle(5);

        $display("[TB] flush kills in-flight port 1 results");
        setReq(1, 27'd11, 27'd13);
        stepPorts(1'b0, 0, 1'b0);
        setReq(1, 27'd6, 27'd6);
        stepPorts(1'b0, 0, 1'b0);
        setReq(1, 27'd5, 27'd5);
        stepPorts(1'b1, 0, 1'b0);
        stepPorts(1'b0, 0, 1'b0);
        idle(5);

        $display("[TB] streaming contention");
        repeat (8) stepPorts(1'b0, 100, 1'b0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(5);

        $display("[TB] reset mid-operation");
        setReq(0, 27'd21, 27'd3);
        stepPorts(1'b0, 0, 1'b0);
        resetCycles(2);
        idle(4);
        setReq(0, 27'd9, 27'd9);
        setReq(1, 27'd8, 27'd8);
        stepPorts(1'b0, 0, 1'b0);
        stepPorts(1'b0, 0, 1'b0);
        idle(5);

        $display("[TB] random traffic with flushes");
        repeat (400) stepPorts($urandom_range(24) == 0, 60, 1'b1);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(LAT + 3);

        checkOutput("drain0", 64'(sbq[0].size()), 64'd0);
        checkOutput("drain1", 64'(sbq[1].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_srv.md
# mul_srv

Shared-multiplier responder for the FMA datapath. It serves the multiply requests issued by the two `fmad` requester ports. It arbitrates round-robin between them, drives one pipelined 27x27 unsigned multiplier, and returns each 54-bit product to the port that issued it a fixed `LAT` cycles after grant. It replaces the combinational priority mux in the FMA top level and is the responder end of the `mulit`/`mulot` request/result interface.

## Interface
- `LAT`, 3, multiplier latency in cycles from grant to result; legal range 1..4.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `flush`  in  1  kill all in-flight operations; blocks grants while high.
- `req0`  in  1  port 0 request; held with operands until `gnt0`.
- `a0`, `b0`  in  27 each  port 0 operands, unsigned.
- `gnt0`  out  1  port 0 request accepted this cycle (combinational).
- `vld0`  out  1  `out0` carries a port 0 result this cycle.
- `out0`  out  54  port 0 product.
- `req1`, `a1`, `b1`, `gnt1`, `vld1`, `out1`: identical set for port 1.

## Operation
- Grant rule, evaluated every cycle:
  - `flush`=1: no grant.
  - Only one `reqN`=1: grant N.
  - Both requesting: grant the port that was not granted most recently (`last` pointer).
  - At most one `gnt` is high in any cycle.
- `last` updates to the granted port on every grant and is unchanged otherwise. Reset value is 1, so port 0 wins the first conflict.
- The losing requester keeps `req` high and its operands stable. Dropping `req` without a grant is legal and has no effect.
- On grant, the operands enter pipeline stage 1 together with a valid bit and a 1-bit port id.
- The product is computed as a full 54-bit unsigned `a*b` with no truncation or rounding. It is retimed across the `LAT` stages.
- At the final stage, valid with id=N:
  - `vldN` goes high for exactly one cycle.
  - `outN` loads the product.
- `outN` holds its last value until the next port N result arrives.
- `flush`=1 clears every stage valid bit on the next edge, so no `vld` fires for killed operations. `outN` keeps its previous value.
- A result leaving the final stage in the same cycle that `flush` is asserted is still delivered. The `vld` is driven from the final-stage register before the clear takes effect.
- Reset at any time clears all pipeline valids and `last`=1. Operations in flight are lost with no `vld`.

## Timing
- Reset values:
  - `gnt0`, `gnt1`, `vld0`, `vld1` = 0.
  - `out0`, `out1` = 0.
  - Pipeline valids = 0.
  - `last` = 1.
- Grant at cycle T gives `vldN`/`outN` at cycle T+`LAT`. For `LAT`=3, a grant at edge-cycle 10 gives the result in cycle 13.
- Throughput is one grant per cycle. Back-to-back grants produce back-to-back `vld` pulses in grant order.
- Under continuous contention the ports alternate 0,1,0,1…, so each port gets ≥1 grant every 2 cycles.
- `gnt` is a combinational function of `req*`, `flush` and `last` only. It has no dependency on `vld`, because the pipeline never stalls.
- Results are never reordered. Per-port results return in that port's grant order.

## Structure
- The shared package `fma_pkg` holds:
  - the `mulit`/`mulot` typedefs;
  - `MUL_W`=27 and `PROD_W`=54;
  - `LAT_MAX`=4.
- Sub-module `mul_pipe` contains the `LAT`-stage multiplier with parallel valid/id shift registers and the flush clear.
- `mul_srv` contains the arbiter, the `last` pointer and the per-port output registers.

## Test plan
- Single request: `req0`, `a0`=3, `b0`=5 at cycle 0 → `gnt0`=1 in cycle 0; `vld0`=1 and `out0`=15 in cycle 3; `vld1` stays 0.
- Conflict: both request from reset, `a0`*`b0`=2*7 and `a1`*`b1`=4*9 → `gnt0` in cycle 0 and `gnt1` in cycle 1; `out0`=14 in cycle 3 and `out1`=36 in cycle 4.
- Maximum operands: `a0`=`b0`=0x7FFFFFF → `out0`=0x3FFFFFF0000001 after `LAT` cycles.
- Flush: grant port 1 at cycles 0 and 1, assert `flush` in cycle 2 → the cycle-0 and cycle-1 results never appear (no `vld1`); `out1` keeps its prior value; no grant in cycle 2.
- Streaming: both ports request continuously for 8 cycles → alternating grants; 8 `vld` pulses in cycles 3..10, each with the correct product.
- Reset mid-operation: assert `reset`=0 in cycle 1 after a cycle-0 grant → all outputs go to 0 immediately, with no `vld` after release. The first post-reset conflict grants port 0.
